// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and widths for the DMA memory-access responder.
//   DMA_AW  : width of the SRAM / DMA address (21-bit address space)
//   DMA_DW  : width of the SRAM / DMA data bus
//   state_t : responder FSM states
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int DMA_AW = 21;
  localparam int DMA_DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // bus not requested
    GRAB    = 2'd1,  // busrq_n asserted, waiting for busak_n
    ACCESS  = 2'd2,  // running SRAM cycles
    RELEASE = 2'd3   // busrq_n released, waiting for busak_n to go high
  } state_t;

endpackage

// File: rtl/bus_sync.sv
// -----------------------------------------------------------------------------
// bus_sync
// STAGES-deep flop chain bringing an asynchronous level into the clk domain.
// Every stage resets to RESET_VAL so that an inactive-high handshake line
// reads as "not asserted" straight out of reset.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   i_async in  asynchronous input level
//   o_sync  out synchronised level (STAGES clocks of latency)
// -----------------------------------------------------------------------------
module bus_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/dma_access.sv
// -----------------------------------------------------------------------------
// dma_access
// Memory-side responder for the DMA request bus. Requests the Z80 bus with
// busrq_n, waits for the synchronised busak_n, then runs SRAM cycles of
// ACCESS_CYCLES clocks each, back to back while dma_req stays high, and hands
// the bus back when requests stop.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   dma_req/rnw/addr/wd     request side (from the DMA arbiter)
//   dma_ack                 pulse: request accepted, addr/wd/rnw sampled
//   dma_end                 pulse: previously acked access complete
//   dma_rd                  read data, valid from dma_end to next dma_end
//   busrq_n / busak_n       Z80 bus request / acknowledge (active low)
//   mem_addr/wd/wd_oe       registered SRAM address, write data, data drive
//   mem_oe_n / mem_we_n     registered SRAM strobes (active low)
//   mem_rd                  SRAM read data
// -----------------------------------------------------------------------------
module dma_access
  import dma_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3,   // legal 3..15
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [DMA_AW-1:0] dma_addr,
  input  logic [DMA_DW-1:0] dma_wd,
  output logic              dma_ack,
  output logic              dma_end,
  output logic [DMA_DW-1:0] dma_rd,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic [DMA_AW-1:0] mem_addr,
  output logic [DMA_DW-1:0] mem_wd,
  output logic              mem_wd_oe,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  input  logic [DMA_DW-1:0] mem_rd
);

  localparam logic [3:0] C_LAST    = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] C_WE_LAST = 4'(ACCESS_CYCLES - 2);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_end;     // high during the END cycle of an access
  logic              r_rnw;
  logic              r_busrq_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_wd_oe;
  logic [DMA_AW-1:0] r_addr;
  logic [DMA_DW-1:0] r_wd;
  logic [DMA_DW-1:0] r_rd;

  logic   w_busak_sync;
  logic   w_c0;
  logic   w_ack;
  logic   w_end_next;
  logic   w_rnw_next;
  logic   w_in_access_next;
  logic   w_oe_n_next;
  logic   w_we_n_next;
  logic   w_wd_oe_next;
  logic   w_busrq_n_next;
  state_t w_state_next;
  logic [3:0] w_cnt_next;

  bus_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_busak_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (busak_n),
    .o_sync  (w_busak_sync)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_end_next   = 1'b0;
    w_rnw_next   = r_rnw;
    w_ack        = 1'b0;
    // Cycle 0 is either the first cycle after the grant (counter at 0) or the
    // END cycle of the previous access (counter saturated, r_end set).
    w_c0         = (r_state == ACCESS) && ((r_cnt == 4'd0) || r_end);

    case (r_state)
      IDLE: begin
        if (dma_req) begin
          w_state_next = GRAB;
          w_cnt_next   = 4'd0;
        end
      end
      GRAB: begin
        if (!dma_req) begin
          w_state_next = RELEASE;
        end else if (!w_busak_sync) begin
          w_state_next = ACCESS;
          w_cnt_next   = 4'd0;
        end
      end
      ACCESS: begin
        if (w_c0) begin
          if (dma_req) begin
            w_ack      = 1'b1;
            w_rnw_next = dma_rnw;
            w_cnt_next = 4'd1;
          end else begin
            w_state_next = RELEASE;
            w_cnt_next   = 4'd0;
          end
        end else if (r_cnt == C_LAST) begin
          // Last strobe cycle: counter holds, next cycle is END.
          w_end_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      RELEASE: begin
        if (w_busak_sync) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Strobes are registered from the next state so the SRAM pins never see
    // decode glitches; c=1..ACCESS_CYCLES-1 of the upcoming cycle.
    w_in_access_next = (w_state_next == ACCESS) && (w_cnt_next != 4'd0) && !w_end_next;
    w_oe_n_next      = !(w_in_access_next && w_rnw_next);
    w_wd_oe_next     = w_in_access_next && !w_rnw_next;
    // Write strobe ends one cycle early so address and data are held.
    w_we_n_next      = !(w_in_access_next && !w_rnw_next && (w_cnt_next <= C_WE_LAST));
    w_busrq_n_next   = (w_state_next == IDLE) || (w_state_next == RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_end     <= 1'b0;
      r_rnw     <= 1'b1;
      r_busrq_n <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_wd_oe   <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_rd      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_end     <= w_end_next;
      r_rnw     <= w_rnw_next;
      r_busrq_n <= w_busrq_n_next;
      r_oe_n    <= w_oe_n_next;
      r_we_n    <= w_we_n_next;
      r_wd_oe   <= w_wd_oe_next;
      if (w_ack) begin
        r_addr <= dma_addr;
        r_wd   <= dma_wd;
      end
      // Capture on the edge closing the last strobe cycle of a read.
      if (w_end_next && r_rnw) begin
        r_rd <= mem_rd;
      end
    end
  end

  assign dma_ack   = w_ack;
  assign dma_end   = r_end;
  assign dma_rd    = r_rd;
  assign busrq_n   = r_busrq_n;
  assign mem_addr  = r_addr;
  assign mem_wd    = r_wd;
  assign mem_wd_oe = r_wd_oe;
  assign mem_oe_n  = r_oe_n;
  assign mem_we_n  = r_we_n;

endmodule

// File: tb/tb_dma_access.sv
// -----------------------------------------------------------------------------
// tb_dma_access
// Directed testbench for dma_access (ACCESS_CYCLES=3, SYNC_STAGES=2).
// The Z80 side answers busrq_n with a one-clock-delayed busak_n unless a test
// forces it; the SRAM returns a fixed pattern only while mem_oe_n is low.
// -----------------------------------------------------------------------------
module tb_dma_access;
  import dma_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        dma_req;
  logic        dma_rnw;
  logic [20:0] dma_addr;
  logic [7:0]  dma_wd;
  logic        dma_ack;
  logic        dma_end;
  logic [7:0]  dma_rd;
  logic        busrq_n;
  logic        busak_n;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wd;
  logic        mem_wd_oe;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [7:0]  mem_rd;

  dma_access #(
    .ACCESS_CYCLES (3),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dma_req   (dma_req),
    .dma_rnw   (dma_rnw),
    .dma_addr  (dma_addr),
    .dma_wd    (dma_wd),
    .dma_ack   (dma_ack),
    .dma_end   (dma_end),
    .dma_rd    (dma_rd),
    .busrq_n   (busrq_n),
    .busak_n   (busak_n),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_wd_oe (mem_wd_oe),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .mem_rd    (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Z80 model: 0 = follow busrq_n one clock late, 1 = never grant, 2 = hold low
  int   busak_mode;
  logic ak_dly;
  always @(posedge clk) ak_dly <= busrq_n;
  assign busak_n = (busak_mode == 1) ? 1'b1 : (busak_mode == 2) ? 1'b0 : ak_dly;

  // SRAM model
  function automatic logic [7:0] rd_model(input logic [20:0] a);
    if (a == 21'h1ABCD) return 8'h5A;
    return a[7:0] ^ 8'h3C;
  endfunction
  assign mem_rd = mem_oe_n ? 8'hEE : rd_model(mem_addr);

  int n_checks;
  int n_pass;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle monitor state
  int          cyc;
  int          n_ack, n_end, n_both, n_oe, n_we, n_wdoe, n_rq_lo, n_rq_bad, we_cyc;
  int          ack_cyc [8];
  int          end_cyc [8];
  logic [7:0]  end_rd  [8];
  logic [20:0] oe_addr, we_addr;
  logic [7:0]  we_wd;

  task automatic clear_mon();
    n_ack = 0; n_end = 0; n_both = 0; n_oe = 0; n_we = 0; n_wdoe = 0;
    n_rq_lo = 0; n_rq_bad = 0; we_cyc = 0;
    oe_addr = '0; we_addr = '0; we_wd = '0;
    for (int i = 0; i < 8; i++) begin
      ack_cyc[i] = 0; end_cyc[i] = 0; end_rd[i] = '0;
    end
  endtask

  // Sample one clock cycle mid-period, then return just after the next edge
  // so the caller can drive inputs for the following cycle.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (busrq_n && (n_ack > n_end)) n_rq_bad++;
    if (dma_ack) begin
      if (n_ack < 8) ack_cyc[n_ack] = cyc;
      n_ack++;
    end
    if (dma_end) begin
      if (n_end < 8) begin
        end_cyc[n_end] = cyc;
        end_rd[n_end]  = dma_rd;
      end
      n_end++;
    end
    if (dma_ack && dma_end) n_both++;
    if (!mem_oe_n) begin n_oe++; oe_addr = mem_addr; end
    if (!mem_we_n) begin n_we++; we_cyc = cyc; we_addr = mem_addr; we_wd = mem_wd; end
    if (mem_wd_oe) n_wdoe++;
    if (!busrq_n) n_rq_lo++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_ack(input int target, input int limit);
    for (int i = 0; i < limit && n_ack < target; i++) cycle();
  endtask

  task automatic wait_end(input int target, input int limit);
    for (int i = 0; i < limit && n_end < target; i++) cycle();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; busak_mode = 0;
    rst_n = 1'b0; dma_req = 1'b0; dma_rnw = 1'b1; dma_addr = '0; dma_wd = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_value("rst_busrq_n",   busrq_n,   1'b1);
    check_value("rst_mem_oe_n",  mem_oe_n,  1'b1);
    check_value("rst_mem_we_n",  mem_we_n,  1'b1);
    check_value("rst_mem_wd_oe", mem_wd_oe, 1'b0);
    check_value("rst_dma_ack",   dma_ack,   1'b0);
    check_value("rst_dma_end",   dma_end,   1'b0);
    check_value("rst_dma_rd",    dma_rd,    8'h00);
    check_value("rst_mem_addr",  mem_addr,  21'h0);
    check_value("rst_mem_wd",    mem_wd,    8'h00);
    rst_n = 1'b1;
    run_cycles(3);

    // 1: single read
    clear_mon();
    dma_rnw = 1'b1; dma_addr = 21'h1ABCD; dma_req = 1'b1;
    wait_ack(1, 40);
    dma_req = 1'b0;
    wait_end(1, 10);
    check_value("t1_busrq_released", busrq_n, 1'b1);
    run_cycles(8);
    check_value("t1_acks",       n_ack, 1);
    check_value("t1_ends",       n_end, 1);
    check_value("t1_oe_cycles",  n_oe, 2);
    check_value("t1_ack_to_end", end_cyc[0] - ack_cyc[0], 3);
    check_value("t1_rd_data",    end_rd[0], 8'h5A);
    check_value("t1_oe_addr",    oe_addr, 21'h1ABCD);
    check_value("t1_busrq_held", n_rq_bad, 0);

    // 2: single write
    clear_mon();
    dma_rnw = 1'b0; dma_addr = 21'h00010; dma_wd = 8'hC3; dma_req = 1'b1;
    wait_ack(1, 40);
    dma_req = 1'b0;
    wait_end(1, 10);
    run_cycles(8);
    check_value("t2_ends",       n_end, 1);
    check_value("t2_wd_oe_cyc",  n_wdoe, 2);
    check_value("t2_we_cycles",  n_we, 1);
    check_value("t2_we_at_c1",   we_cyc - ack_cyc[0], 1);
    check_value("t2_we_data",    we_wd, 8'hC3);
    check_value("t2_we_addr",    we_addr, 21'h00010);
    check_value("t2_no_oe",      n_oe, 0);
    check_value("t2_rd_held",    end_rd[0], 8'h5A);

    // 3: four back-to-back reads at 0x100..0x103
    clear_mon();
    dma_rnw = 1'b1; dma_addr = 21'h100; dma_req = 1'b1;
    for (int i = 0; i < 80 && n_ack < 4; i++) begin
      cycle();
      dma_addr = 21'h100 + 21'(n_ack);
    end
    dma_req = 1'b0;
    wait_end(4, 10);
    run_cycles(8);
    check_value("t3_acks",       n_ack, 4);
    check_value("t3_ends",       n_end, 4);
    check_value("t3_ack_end_overlap", n_both, 3);
    check_value("t3_spacing_1",  ack_cyc[1] - ack_cyc[0], 3);
    check_value("t3_spacing_2",  ack_cyc[2] - ack_cyc[1], 3);
    check_value("t3_spacing_3",  ack_cyc[3] - ack_cyc[2], 3);
    check_value("t3_last_end",   end_cyc[3] - ack_cyc[3], 3);
    check_value("t3_rd_0",       end_rd[0], 8'h3C);
    check_value("t3_rd_1",       end_rd[1], 8'h3D);
    check_value("t3_rd_2",       end_rd[2], 8'h3E);
    check_value("t3_rd_3",       end_rd[3], 8'h3F);
    check_value("t3_busrq_held", n_rq_bad, 0);

    // 4: request pulse with no grant, then abort
    clear_mon();
    busak_mode = 1;
    dma_rnw = 1'b1; dma_addr = 21'h00400; dma_req = 1'b1;
    run_cycles(2);
    dma_req = 1'b0;
    run_cycles(15);
    check_value("t4_grab_seen",  (n_rq_lo > 0), 1'b1);
    check_value("t4_no_ack",     n_ack, 0);
    check_value("t4_no_end",     n_end, 0);
    check_value("t4_busrq_n",    busrq_n, 1'b1);
    busak_mode = 0;
    run_cycles(4);

    // 5: reset during c=1 of a write
    clear_mon();
    dma_rnw = 1'b0; dma_addr = 21'h00055; dma_wd = 8'h77; dma_req = 1'b1;
    wait_ack(1, 40);
    dma_req = 1'b0;
    check_value("t5_we_at_c1",    mem_we_n, 1'b0);
    check_value("t5_wd_oe_at_c1", mem_wd_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check_value("t5_rst_we_n",    mem_we_n, 1'b1);
    check_value("t5_rst_wd_oe",   mem_wd_oe, 1'b0);
    check_value("t5_rst_busrq_n", busrq_n, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycles(10);
    check_value("t5_no_end",      n_end, 0);
    check_value("t5_state_idle",  32'(dut.r_state), 32'(IDLE));

    // 6: new request while the bus is still being released
    clear_mon();
    dma_rnw = 1'b1; dma_addr = 21'h00020; dma_req = 1'b1;
    wait_ack(1, 40);
    dma_req = 1'b0;
    wait_end(1, 10);
    check_value("t6_first_rd",    end_rd[0], 8'h1C);
    busak_mode = 2;
    clear_mon();
    dma_addr = 21'h02222; dma_req = 1'b1;
    run_cycles(10);
    check_value("t6_no_ack_in_release", n_ack, 0);
    check_value("t6_no_regrab",   n_rq_lo, 0);
    busak_mode = 0;
    wait_ack(1, 40);
    dma_req = 1'b0;
    wait_end(1, 10);
    run_cycles(8);
    check_value("t6_acks",        n_ack, 1);
    check_value("t6_rd",          end_rd[0], 8'h1E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_access.md
Name: dma_access

Overview:
- Memory-side responder for the DMA request bus: consumes dma_req/dma_addr/dma_rnw/dma_wd and returns dma_ack/dma_end/dma_rd.
- Acquires the Z80 bus via BUSRQ/BUSAK, then runs back-to-back SRAM cycles on the 21-bit address space.
- Releases the bus when requests stop.
- Sits between the DMA request arbiter and the SRAM pin drivers.

Parameters:
- ACCESS_CYCLES, 3, clocks per SRAM access; legal range 3..15.
- SYNC_STAGES, 2, synchroniser depth for busak_n.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- dma_req  in  1  any DMA request pending.
- dma_rnw  in  1  1 = read, 0 = write; valid while dma_req is high.
- dma_addr  in  21  access address.
- dma_wd  in  8  write data.
- dma_ack  out  1  one-clock pulse: request accepted; addr/wd/rnw sampled this cycle.
- dma_end  out  1  one-clock pulse: previously acked access complete.
- dma_rd  out  8  read data; valid from the dma_end cycle until the next dma_end.
- busrq_n  out  1  Z80 bus request, active low.
- busak_n  in  1  Z80 bus acknowledge, active low, asynchronous.
- mem_addr  out  21  SRAM address, registered.
- mem_wd  out  8  SRAM write data, registered.
- mem_wd_oe  out  1  drive data bus (writes only).
- mem_oe_n  out  1  SRAM output enable, active low.
- mem_we_n  out  1  SRAM write enable, active low.
- mem_rd  in  8  SRAM data bus input.

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk. Reset values:
  - busrq_n=1, mem_oe_n=1, mem_we_n=1, mem_wd_oe=0.
  - dma_ack=0, dma_end=0, dma_rd=0, mem_addr=0, mem_wd=0.
  - state=IDLE, counter=0.
- Reset mid-access forces all of the above immediately, with no dma_end for the aborted access.
- busak_n passes through a SYNC_STAGES flop chain; "granted" means the synchronised value is 0.
- IDLE:
  - busrq_n=1.
  - On dma_req=1: go to GRAB, assert busrq_n=0 from the next clock.
- GRAB:
  - Wait for granted.
  - If dma_req drops before grant, go to RELEASE.
  - On grant with dma_req=1, go to ACCESS at cycle 0.
- ACCESS (counter c = 0..ACCESS_CYCLES-1):
  - c=0:
    - dma_ack=1.
    - Latch dma_addr→mem_addr, dma_wd→mem_wd, dma_rnw into an internal rnw register (all visible from c=1).
  - Read:
    - mem_oe_n=0 for c=1..ACCESS_CYCLES-1.
    - mem_rd is captured into the data register on the clock edge ending c=ACCESS_CYCLES-1.
  - Write:
    - mem_wd_oe=1 for c=1..ACCESS_CYCLES-1.
    - mem_we_n=0 for c=1..ACCESS_CYCLES-2, giving address and data hold in the last cycle.
- Cycle following c=ACCESS_CYCLES-1 ("END cycle"):
  - dma_end=1.
  - dma_rd shows the captured data (reads); for writes dma_rd holds its previous value.
  - If dma_req=1 in the END cycle, that cycle is also c=0 of the next access, with dma_ack=1 simultaneously. This gives back-to-back throughput of one access per ACCESS_CYCLES clocks.
  - If dma_req=0 in the END cycle, go to RELEASE.
- dma_ack and dma_end coincide only in the back-to-back case; the dma_end always refers to the earlier ack.
- RELEASE:
  - busrq_n=1, all mem strobes inactive.
  - Wait for synchronised busak_n=1, then go to IDLE.
  - dma_req arriving during RELEASE is ignored until IDLE, which then re-grabs.
- dma_req dropping between an ack and its end does not abort the access; dma_end is still produced.
- Exactly one dma_end per dma_ack, always.
- Counter saturates at ACCESS_CYCLES-1 and wraps to 0 only on a back-to-back start.

Decomposition:
- Package dma_pkg:
  - state enum {IDLE, GRAB, ACCESS, RELEASE}.
  - DMA_AW=21, DMA_DW=8.
- One sub-module: bus_sync (SYNC_STAGES-deep synchroniser, reset value 1) for busak_n.
- FSM, counter and strobe generation stay in dma_access.

Test Plan:
1. Single read, ACCESS_CYCLES=3, busak_n tied to busrq_n with 1-clock delay: dma_req=1, rnw=1, addr=0x1ABCD, mem_rd=0x5A → busrq_n low; after sync, one dma_ack; mem_addr=0x1ABCD; mem_oe_n low 2 clocks; dma_end one clock later with dma_rd=0x5A; busrq_n returns high.
2. Single write: addr=0x00010, wd=0xC3 → mem_wd_oe high 2 clocks, mem_we_n low exactly 1 clock (c=1), mem_wd=0xC3, one dma_end, dma_rd unchanged.
3. Back-to-back: dma_req held for 4 reads at addresses 0x100..0x103 → 4 acks spaced 3 clocks apart; acks 2..4 coincide with ends 1..3; final end alone; busrq_n held low throughout.
4. Grant delay and abort: dma_req pulsed 2 clocks, busak_n never asserted → GRAB, then RELEASE, busrq_n=1; no dma_ack or dma_end emitted.
5. Reset mid-access: assert rst_n=0 at c=1 of a write → mem_we_n=1, mem_wd_oe=0, busrq_n=1 asynchronously; after release no dma_end is seen and the FSM is in IDLE.
6. Request during RELEASE: new dma_req while busak_n still low → no ack until busak_n high is synchronised, then a fresh GRAB and normal access.
